// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the add/subtract sequencer and its arithmetic core.
package addsub_seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD_A = 2'd1,
    SUB_B = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_core.sv
// Combinational adder-subtractor: s = x + (y ^ {WIDTH{op}}) + op, with signed overflow flag.
module addsub_core #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             op,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] y_eff;

  always_comb begin
    y_eff       = y ^ {WIDTH{op}};
    {cout, s}   = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, op};
    // Overflow when both effective operands share a sign the result does not.
    ovf         = (x[WIDTH-1] == y_eff[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  end

endmodule

// File: rtl/addsub_sequencer.sv
// Sequences one adder-subtractor to compute m*A - n*B into an accumulator,
// with valid/ready handshakes on the command and result sides.
module addsub_sequencer
  import addsub_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CNT_W-1:0] m,
  input  logic [CNT_W-1:0] n,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // start_ready is high only in IDLE; done_valid holds until done_ready is seen with it.

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [WIDTH-1:0] acc;
  logic             core_op;
  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] core_s;
  logic             core_ovf;

  always_comb begin
    core_op = (state == SUB_B) ? OP_SUB : OP_ADD;
    core_y  = (state == SUB_B) ? b_q : a_q;
  end

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .x    (acc),
    .y    (core_y),
    .op   (core_op),
    .s    (core_s),
    .cout (),
    .ovf  (core_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_a       <= '0;
      cnt_b       <= '0;
      acc         <= '0;
      ovf         <= 1'b0;
      done_valid  <= 1'b0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q         <= a;
            b_q         <= b;
            cnt_a       <= m;
            cnt_b       <= n;
            acc         <= '0;
            ovf         <= 1'b0;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            if (m != '0)      state <= ADD_A;
            else if (n != '0) state <= SUB_B;
            else              state <= DONE;
          end
        end
        ADD_A: begin
          acc   <= core_s;
          ovf   <= ovf | core_ovf;
          cnt_a <= cnt_a - CNT_W'(1);
          if (cnt_a == CNT_W'(1)) state <= (cnt_b != '0) ? SUB_B : DONE;
        end
        SUB_B: begin
          acc   <= core_s;
          ovf   <= ovf | core_ovf;
          cnt_b <= cnt_b - CNT_W'(1);
          if (cnt_b == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          // First DONE cycle only raises done_valid, giving the m+n+1 latency.
          if (done_valid && done_ready) begin
            state       <= IDLE;
            done_valid  <= 1'b0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            done_valid  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign result    = acc;
  assign fsm_state = state;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed bench for addsub_sequencer: hand-computed vectors checked with immediate assertions.
module tb_addsub_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  m;
  logic [3:0]  n;
  logic        done_valid;
  logic        done_ready;
  logic [15:0] result;
  logic        ovf;
  logic        busy;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  addsub_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .m           (m),
    .n           (n),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .result      (result),
    .ovf         (ovf),
    .busy        (busy),
    .fsm_state   (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a command and wait for done_valid; returns cycles from the accepting edge.
  task automatic issue(input logic [15:0] av, input logic [15:0] bv,
                       input logic [3:0] mv, input logic [3:0] nv, output int lat);
    int guard;
    guard = 0;
    while (!start_ready && guard < 64) begin step(); guard++; end
    check("start_ready_before_cmd", {31'd0, start_ready}, 32'd1);
    a = av; b = bv; m = mv; n = nv;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; m = 4'hF; n = 4'hF;
    lat = 0;
    while (!done_valid && lat < 64) begin step(); lat++; end
  endtask

  task automatic run_cmd(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic [3:0] mv, input logic [3:0] nv,
                         input logic [15:0] exp_res, input logic exp_ovf);
    int lat;
    issue(av, bv, mv, nv, lat);
    check({tag, "_latency"}, lat, 32'(mv) + 32'(nv) + 32'd1);
    check({tag, "_result"}, {16'd0, result}, {16'd0, exp_res});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    check({tag, "_done_cleared"}, {31'd0, done_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, start_ready}, 32'd1);
    check({tag, "_result_held"}, {16'd0, result}, {16'd0, exp_res});
  endtask

  initial begin
    int lat;
    int seen_done;
    logic [15:0] held;
    rst_n = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
    a = '0; b = '0; m = '0; n = '0;
    #12;
    check("reset_result", {16'd0, result}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);
    check("reset_done_valid", {31'd0, done_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_start_ready", {31'd0, start_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    step();

    run_cmd("t1_3a_minus_2b", 16'd5, 16'd3, 4'd3, 4'd2, 16'h0009, 1'b0);
    run_cmd("t2_zero_coeffs", 16'h1234, 16'h1234, 4'd0, 4'd0, 16'h0000, 1'b0);
    run_cmd("t3_add_ovf", 16'h4000, 16'h0000, 4'd2, 4'd0, 16'h8000, 1'b1);
    run_cmd("t3_ovf_cleared", 16'h0001, 16'h0000, 4'd1, 4'd0, 16'h0001, 1'b0);
    run_cmd("t4_sub_wrap", 16'h0000, 16'h0001, 4'd0, 4'd1, 16'hFFFF, 1'b0);
    run_cmd("t4_sub_ovf", 16'h0000, 16'h8000, 4'd0, 4'd1, 16'h8000, 1'b1);
    run_cmd("mixed_sub_ovf", 16'h7FFF, 16'hFFFF, 4'd1, 4'd1, 16'h8000, 1'b1);
    run_cmd("max_coeffs", 16'd3, 16'd2, 4'd15, 4'd15, 16'd15, 1'b0);

    // Result stalled by consumer; a new command must be ignored.
    issue(16'd7, 16'd2, 4'd2, 4'd1, lat);
    check("t5_latency", lat, 32'd4);
    check("t5_result", {16'd0, result}, 32'd12);
    held = result;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a = 16'h0100; b = 16'h0001; m = 4'd1; n = 4'd1; start_valid = 1'b1;
      end
      step();
      start_valid = 1'b0;
      check("t5_hold_result", {16'd0, result}, {16'd0, held});
      check("t5_hold_valid", {31'd0, done_valid}, 32'd1);
      check("t5_hold_not_ready", {31'd0, start_ready}, 32'd0);
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    check("t5_released_valid", {31'd0, done_valid}, 32'd0);
    check("t5_released_ready", {31'd0, start_ready}, 32'd1);
    check("t5_released_busy", {31'd0, busy}, 32'd0);
    step();
    check("t5_ignored_stays_idle", {31'd0, busy}, 32'd0);
    check("t5_ignored_result", {16'd0, result}, 32'd12);

    // Reset mid-sequence.
    a = 16'd1; b = 16'd0; m = 4'd15; n = 4'd0; start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step(); step(); step();
    check("t6_busy_before_reset", {31'd0, busy}, 32'd1);
    check("t6_acc_progress", {16'd0, result}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("t6_reset_result", {16'd0, result}, 32'd0);
    check("t6_reset_ovf", {31'd0, ovf}, 32'd0);
    check("t6_reset_busy", {31'd0, busy}, 32'd0);
    check("t6_reset_done_valid", {31'd0, done_valid}, 32'd0);
    check("t6_reset_start_ready", {31'd0, start_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done_valid) seen_done++;
    end
    check("t6_no_done_after_reset", seen_done, 32'd0);
    check("t6_ready_after_release", {31'd0, start_ready}, 32'd1);
    check("t6_state_idle", {30'd0, fsm_state}, 32'd0);

    run_cmd("post_reset_cmd", 16'd10, 16'd4, 4'd2, 4'd3, 16'd8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
